// File: rtl/alu_flag_producer_pkg.sv
// alu_flag_pkg: shared opcode and FSM state encodings for the chunk-serial add/sub unit
package alu_flag_pkg;
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_e;
endpackage

// File: rtl/alu_flag_producer_if.sv
// alu_flag_producer_if: operand issue and result/flag handshake between issue logic, producer and comparer
interface alu_flag_producer_if #(parameter int WIDTH = 32);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             zero;
  logic             sign;
  logic             overflow;
  modport master (output in_valid, a, b, op, out_ready,
                  input  in_ready, out_valid, result, cout, zero, sign, overflow);
  modport slave  (input  in_valid, a, b, op, out_ready,
                  output in_ready, out_valid, result, cout, zero, sign, overflow);
endinterface

// File: rtl/alu_flag_producer_chunk_adder.sv
// chunk_adder: CHUNK-bit ripple adder exposing the carry into its top bit for overflow detection
module chunk_adder #(parameter int CHUNK = 4) (
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout,
  output logic             c_msb_in
);
  logic [CHUNK:0] c;
  always_comb begin
    c = '0;
    sum = '0;
    c[0] = cin;
    for (int i = 0; i < CHUNK; i++) begin
      sum[i] = x[i] ^ y[i] ^ c[i];
      c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
    end
  end
  assign cout = c[CHUNK];
  assign c_msb_in = c[CHUNK-1];
endmodule

// File: rtl/alu_flag_producer.sv
// alu_flag_producer: chunk-serial add/subtract producing result and cout/zero/sign/overflow flags
module alu_flag_producer
  import alu_flag_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 4
) (
  input logic clk,
  input logic reset,
  alu_flag_producer_if.slave bus
);
  localparam int N = WIDTH / CHUNK;
  localparam int CW = N > 1 ? $clog2(N) : 1;
  if (WIDTH % CHUNK != 0) begin : g_bad_chunk
    $error("alu_flag_producer: WIDTH must be a multiple of CHUNK");
  end
  state_e           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] opa_q, opb_q, res_sh_q, res_sh_d, result_q;
  logic             carry_q, zacc_q, zacc_d;
  logic             in_ready_q, out_valid_q, cout_q, zero_q, sign_q, ovf_q;
  logic [CHUNK-1:0] sum;
  logic             c_out, c_msb;
  chunk_adder #(.CHUNK(CHUNK)) u_add (
    .x(opa_q[CHUNK-1:0]),
    .y(opb_q[CHUNK-1:0]),
    .cin(carry_q),
    .sum(sum),
    .cout(c_out),
    .c_msb_in(c_msb)
  );
  // each sum chunk enters at the MSB end, so after N steps chunk 0 sits at the LSB
  always_comb begin
    res_sh_d = (res_sh_q >> CHUNK) | (WIDTH'(sum) << (WIDTH - CHUNK));
    zacc_d = zacc_q & (sum == '0);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      in_ready_q <= 1'b1;
      out_valid_q <= 1'b0;
      cnt_q <= '0;
      opa_q <= '0;
      opb_q <= '0;
      res_sh_q <= '0;
      result_q <= '0;
      carry_q <= 1'b0;
      zacc_q <= 1'b0;
      cout_q <= 1'b0;
      zero_q <= 1'b0;
      sign_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: if (bus.in_valid) begin
          opa_q <= bus.a;
          opb_q <= bus.op == OP_SUB ? ~bus.b : bus.b;
          carry_q <= bus.op;
          cnt_q <= '0;
          zacc_q <= 1'b1;
          in_ready_q <= 1'b0;
          state_q <= ST_RUN;
        end
        ST_RUN: begin
          opa_q <= opa_q >> CHUNK;
          opb_q <= opb_q >> CHUNK;
          res_sh_q <= res_sh_d;
          carry_q <= c_out;
          zacc_q <= zacc_d;
          if (cnt_q == CW'(N - 1)) begin
            result_q <= res_sh_d;
            cout_q <= c_out;
            zero_q <= zacc_d;
            sign_q <= res_sh_d[WIDTH-1];
            ovf_q <= c_msb ^ c_out;
            out_valid_q <= 1'b1;
            state_q <= ST_DONE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        ST_DONE: if (bus.out_ready) begin
          out_valid_q <= 1'b0;
          in_ready_q <= 1'b1;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end
  assign bus.in_ready = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.result = result_q;
  assign bus.cout = cout_q;
  assign bus.zero = zero_q;
  assign bus.sign = sign_q;
  assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_alu_flag_producer.sv
// tb_alu_flag_producer: directed self-checking bench for the chunk-serial add/sub flag producer
module tb_alu_flag_producer;
  logic clk = 1'b0;
  logic reset;
  int checks = 0;
  int failures = 0;
  alu_flag_producer_if #(.WIDTH(8)) bus ();
  alu_flag_producer #(.WIDTH(8), .CHUNK(2)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;

  task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic op);
    bus.a = a;
    bus.b = b;
    bus.op = op;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_out(output int n);
    n = 0;
    while (bus.out_valid !== 1'b1 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic release_out();
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    checks++;
    if ({bus.in_ready, bus.out_valid} !== 2'b10) begin
      failures++;
      $display("FAIL reset_handshake got ready/valid=%b exp=10", {bus.in_ready, bus.out_valid});
    end
    checks++;
    if ({bus.result, bus.cout, bus.zero, bus.sign, bus.overflow} !== 12'h000) begin
      failures++;
      $display("FAIL reset_outputs got=%h exp=000", {bus.result, bus.cout, bus.zero, bus.sign, bus.overflow});
    end
  endtask

  task automatic test_add();
    int n;
    issue(8'h05, 8'h03, 1'b0);
    wait_out(n);
    checks++;
    if (n != 4) begin
      failures++;
      $display("FAIL add_latency got=%0d exp=4", n);
    end
    checks++;
    if ({bus.result, bus.cout, bus.zero, bus.sign, bus.overflow} !== {8'h08, 4'b0000}) begin
      failures++;
      $display("FAIL add_05_03 got=%h exp=%h", {bus.result, bus.cout, bus.zero, bus.sign, bus.overflow}, {8'h08, 4'b0000});
    end
    checks++;
    if (bus.in_ready !== 1'b0) begin
      failures++;
      $display("FAIL done_in_ready got=%b exp=0", bus.in_ready);
    end
    release_out();
    checks++;
    if ({bus.in_ready, bus.out_valid} !== 2'b10) begin
      failures++;
      $display("FAIL add_release got ready/valid=%b exp=10", {bus.in_ready, bus.out_valid});
    end
  endtask

  // vectors: a, b, op, expected {result, cout, zero, sign, overflow}
  task automatic test_arith(input string name, input logic [7:0] va[2], input logic [7:0] vb[2],
                            input logic vop[2], input logic [11:0] vexp[2]);
    int n;
    for (int i = 0; i < 2; i++) begin
      issue(va[i], vb[i], vop[i]);
      wait_out(n);
      checks++;
      if (n != 4) begin
        failures++;
        $display("FAIL %s_%0d_latency got=%0d exp=4", name, i, n);
      end
      checks++;
      if ({bus.result, bus.cout, bus.zero, bus.sign, bus.overflow} !== vexp[i]) begin
        failures++;
        $display("FAIL %s_%0d got=%h exp=%h", name, i, {bus.result, bus.cout, bus.zero, bus.sign, bus.overflow}, vexp[i]);
      end
      release_out();
    end
  endtask

  task automatic test_sub();
    test_arith("sub", '{8'h05, 8'h03}, '{8'h05, 8'h05}, '{1'b1, 1'b1}, '{{8'h00, 4'b1100}, {8'hFE, 4'b0010}});
  endtask

  task automatic test_overflow();
    test_arith("ovf", '{8'h7F, 8'h80}, '{8'h01, 8'h01}, '{1'b0, 1'b1}, '{{8'h80, 4'b0011}, {8'h7F, 4'b1001}});
  endtask

  task automatic test_hold_and_ignore();
    int n;
    issue(8'h90, 8'h90, 1'b0);
    checks++;
    if (bus.in_ready !== 1'b0) begin
      failures++;
      $display("FAIL run_in_ready got=%b exp=0", bus.in_ready);
    end
    bus.a = 8'hFF;
    bus.b = 8'hFF;
    bus.op = 1'b1;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    checks++;
    if (bus.in_ready !== 1'b0) begin
      failures++;
      $display("FAIL run_ignore_in_ready got=%b exp=0", bus.in_ready);
    end
    wait_out(n);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({bus.out_valid, bus.result, bus.cout, bus.zero, bus.sign, bus.overflow} !== {1'b1, 8'h20, 4'b1001}) begin
        failures++;
        $display("FAIL hold_%0d got=%h exp=%h", i, {bus.out_valid, bus.result, bus.cout, bus.zero, bus.sign, bus.overflow}, {1'b1, 8'h20, 4'b1001});
      end
      @(posedge clk);
      #1;
    end
    release_out();
  endtask

  task automatic test_reset_mid_run();
    int n;
    issue(8'h12, 8'h34, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    checks++;
    if ({bus.in_ready, bus.out_valid} !== 2'b10) begin
      failures++;
      $display("FAIL midreset_handshake got ready/valid=%b exp=10", {bus.in_ready, bus.out_valid});
    end
    checks++;
    if ({bus.result, bus.cout, bus.zero, bus.sign, bus.overflow} !== 12'h000) begin
      failures++;
      $display("FAIL midreset_outputs got=%h exp=000", {bus.result, bus.cout, bus.zero, bus.sign, bus.overflow});
    end
    repeat (6) @(posedge clk);
    #1;
    checks++;
    if (bus.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL midreset_discard got out_valid=%b exp=0", bus.out_valid);
    end
    issue(8'h01, 8'h01, 1'b0);
    wait_out(n);
    checks++;
    if (n != 4) begin
      failures++;
      $display("FAIL post_reset_latency got=%0d exp=4", n);
    end
    checks++;
    if ({bus.result, bus.cout, bus.zero, bus.sign, bus.overflow} !== {8'h02, 4'b0000}) begin
      failures++;
      $display("FAIL post_reset_add got=%h exp=%h", {bus.result, bus.cout, bus.zero, bus.sign, bus.overflow}, {8'h02, 4'b0000});
    end
    release_out();
  endtask

  initial begin
    reset = 1'b1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.op = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_add();
    test_sub();
    test_overflow();
    test_hold_and_ignore();
    test_reset_mid_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/alu_flag_producer.md
Name: alu_flag_producer

Overview:
- Multi-cycle, chunk-serial add/subtract unit. It produces the result bus and the cout/zero/sign/overflow flag set that the comparer consumes to derive eql/slt.
- It is the producing end of the ALU flag interface. It sits between the operand/issue logic and the comparer.
- It processes CHUNK bits per cycle and uses a valid/ready handshake on both its input side and its output side.

Parameters:
- WIDTH, 32, operand and result width in bits.
- CHUNK, 4, bits processed per cycle. WIDTH % CHUNK must equal 0; any other value is an elaboration error.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  operands and op are presented.
- in_ready  output  1  unit can accept a new operation.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- op  input  1  0 = add (a+b), 1 = subtract (a-b).
- out_valid  output  1  result and flags are valid.
- out_ready  input  1  consumer accepts the result.
- result  output  WIDTH  sum or difference.
- cout  output  1  carry out of the MSB. For subtract this is the carry of a + ~b + 1, so 1 means no borrow.
- zero  output  1  result == 0.
- sign  output  1  result[WIDTH-1].
- overflow  output  1  signed overflow = carry into MSB XOR carry out of MSB.

Behaviour:
- Reset (synchronous, active-high; applies at any time, including mid-operation):
  - state goes to IDLE; any in-flight operation is discarded.
  - in_ready = 1, out_valid = 0.
  - result, cout, zero, sign and overflow all = 0.
- States: IDLE, RUN, DONE. N = WIDTH/CHUNK.
- IDLE:
  - in_ready = 1.
  - On in_valid, capture a into opa_sh and (op ? ~b : b) into opb_sh; carry = op; cnt = 0; zero_acc = 1; then go to RUN.
- RUN:
  - in_ready = 0; in_valid is ignored.
  - Each cycle, the low CHUNK bits of opa_sh and opb_sh go through chunk_adder with carry-in = carry.
  - The sum chunk shifts into result_sh from the MSB side; both operand shifters shift right by CHUNK.
  - carry is updated; zero_acc &= (sum chunk == 0).
  - When cnt == N-1: latch the flags (overflow uses that chunk's carry into its top bit), then go to DONE. Otherwise cnt++.
- DONE:
  - out_valid = 1; result and flags are held stable while out_ready = 0.
  - On out_ready, go to IDLE; out_valid deasserts on the next cycle.
- Latency and throughput:
  - Accept occurs at edge 0; out_valid is high from edge N onward.
  - One operation per N+2 cycles minimum. There is no overlap of input and output.
- Outputs are registered. Flag outputs change only on the RUN-to-DONE transition or on reset.
- Width rules:
  - All arithmetic is modulo 2^WIDTH.
  - The subtract carry-in of 1 enters only the first chunk.
- Counter: cnt is $clog2(N) bits, minimum 1 bit. N = 1 (CHUNK = WIDTH) is legal and gives a single-cycle RUN.

Decomposition:
- Package alu_flag_pkg holds:
  - OP_ADD = 1'b0 and OP_SUB = 1'b1.
  - The state encoding: ST_IDLE, ST_RUN, ST_DONE.
- Sub-module chunk_adder: a parameterised CHUNK-bit ripple adder.
  - Inputs: x, y, cin.
  - Outputs: sum, cout, c_msb_in (carry into the top bit of the chunk, used for overflow).

Test Plan (WIDTH=8, CHUNK=2, N=4):
- add 8'h05 + 8'h03 -> result 8'h08, cout 0, zero 0, sign 0, overflow 0; out_valid rises exactly 4 cycles after accept.
- sub 8'h05 - 8'h05 -> result 8'h00, cout 1, zero 1, sign 0, overflow 0.
- sub 8'h03 - 8'h05 -> result 8'hFE, cout 0, zero 0, sign 1, overflow 0.
- add 8'h7F + 8'h01 -> result 8'h80, cout 0, sign 1, overflow 1. Then sub 8'h80 - 8'h01 -> result 8'h7F, cout 1, sign 0, overflow 1.
- Hold out_ready = 0 for 3 cycles in DONE -> out_valid and all outputs remain stable. Pulse in_valid with new operands during RUN -> ignored, and in_ready stays 0.
- Assert reset for one cycle at RUN cnt = 2 -> next cycle out_valid 0, in_ready 1, all flags 0. A following add 8'h01 + 8'h01 -> result 8'h02, completing normally.
